// File: rtl/proc_fetch_buffer_if.sv
// Fetch buffer bus bundle: redirect input, instruction-memory request and
// response channels, and the decode-side instruction channel.
// The master modport is the fetch buffer; the slave modport is its environment.
interface proc_fetch_buffer_if #(
  parameter int p_depth = 4
);
  localparam int lp_cnt_w = $clog2(p_depth) + 1;

  logic                redirect_val;
  logic [31:0]         redirect_pc;
  logic                imem_req_val;
  logic                imem_req_rdy;
  logic [31:0]         imem_req_addr;
  logic                imem_resp_val;
  logic                imem_resp_rdy;
  logic [31:0]         imem_resp_data;
  logic                inst_val;
  logic                inst_rdy;
  logic [31:0]         inst_data;
  logic [31:0]         inst_pc;
  logic [lp_cnt_w-1:0] count;

  modport master (
    input  redirect_val, redirect_pc,
    input  imem_req_rdy, imem_resp_val, imem_resp_data,
    input  inst_rdy,
    output imem_req_val, imem_req_addr, imem_resp_rdy,
    output inst_val, inst_data, inst_pc, count
  );

  modport slave (
    output redirect_val, redirect_pc,
    output imem_req_rdy, imem_resp_val, imem_resp_data,
    output inst_rdy,
    input  imem_req_val, imem_req_addr, imem_resp_rdy,
    input  inst_val, inst_data, inst_pc, count
  );
endinterface

// File: rtl/proc_fetch_buffer.sv
// Instruction fetch buffer. Issues sequential fetch requests under a credit
// scheme (requests in flight plus queued entries never exceed the queue depth),
// queues in-order responses with their PC, and squashes both the queue and
// the responses still in flight when the pipeline redirects.
module proc_fetch_buffer #(
  parameter int          p_depth        = 4,
  parameter logic [31:0] p_reset_vector = 32'h200
) (
  input logic                 clk,
  input logic                 reset,
  proc_fetch_buffer_if.master bus
);

  localparam int lp_ptr_w = $clog2(p_depth);
  localparam int lp_cnt_w = lp_ptr_w + 1;
  localparam logic [lp_cnt_w:0] lp_depth = (lp_cnt_w + 1)'(p_depth);

  logic [31:0]         r_fetch_pc;
  logic [31:0]         r_resp_pc;
  logic [lp_cnt_w-1:0] r_count;
  logic [lp_cnt_w-1:0] r_inflight;
  logic [lp_cnt_w-1:0] r_drop_cnt;
  logic [lp_ptr_w-1:0] r_head;
  logic [lp_ptr_w-1:0] r_tail;
  logic [31:0]         r_q_data [p_depth];
  logic [31:0]         r_q_pc   [p_depth];

  logic                w_credit_ok;
  logic [lp_cnt_w:0]   w_credit_used;
  logic                w_req_val;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_inst_val;
  logic                w_inst_fire;
  logic                w_drop;
  logic                w_enq;
  logic                w_deq;

  // Handshake qualification; every output is held quiet while reset is low,
  // so no fire can occur during reset.
  always_comb begin
    w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
    w_credit_ok   = (w_credit_used < lp_depth);
    w_req_val     = reset & ~bus.redirect_val & w_credit_ok;
    w_req_fire    = w_req_val & bus.imem_req_rdy;
    w_resp_fire   = reset & bus.imem_resp_val;
    w_inst_val    = reset & (r_count != '0);
    w_inst_fire   = w_inst_val & bus.inst_rdy;
    // A response fired in the redirect cycle belongs to the squashed stream.
    w_drop        = w_resp_fire & (bus.redirect_val | (r_drop_cnt != '0));
    w_enq         = w_resp_fire & ~w_drop;
    w_deq         = w_inst_fire & ~bus.redirect_val;
  end

  assign bus.imem_req_val  = w_req_val;
  assign bus.imem_req_addr = r_fetch_pc;
  assign bus.imem_resp_rdy = reset;
  assign bus.inst_val      = w_inst_val;
  assign bus.inst_data     = reset ? r_q_data[r_head] : 32'h0;
  assign bus.inst_pc       = reset ? r_q_pc[r_head]   : 32'h0;
  assign bus.count         = reset ? r_count          : '0;

  // Fetch/response PCs, credit counters, queue pointers and redirect handling.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= p_reset_vector;
      r_resp_pc  <= p_reset_vector;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      // Requests never fire during a redirect, so this also yields the
      // post-redirect in-flight count.
      case ({w_req_fire, w_resp_fire})
        2'b10:   r_inflight <= r_inflight + lp_cnt_w'(1);
        2'b01:   r_inflight <= r_inflight - lp_cnt_w'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (bus.redirect_val) begin
        // Everything still in flight after this cycle is from the old stream;
        // recomputed from scratch rather than added to any old drop count.
        r_drop_cnt <= w_resp_fire ? (r_inflight - lp_cnt_w'(1)) : r_inflight;
        r_fetch_pc <= bus.redirect_pc;
        r_resp_pc  <= bus.redirect_pc;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - lp_cnt_w'(1);
        end
        if (w_enq) begin
          r_tail    <= r_tail + lp_ptr_w'(1);
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_deq) begin
          r_head <= r_head + lp_ptr_w'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + lp_cnt_w'(1);
          2'b01:   r_count <= r_count - lp_cnt_w'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage: accepted response word tagged with its PC at the tail.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_data[r_tail] <= bus.imem_resp_data;
      r_q_pc[r_tail]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_proc_fetch_buffer.sv
// Bench for proc_fetch_buffer: a 1-cycle-latency memory model, a scoreboard
// of expected {pc, word} pairs pushed by the directed stimulus, and a monitor
// that checks every instruction handed to decode.
module tb_proc_fetch_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;

  proc_fetch_buffer_if #(.p_depth(4)) bus ();

  proc_fetch_buffer #(
    .p_depth       (4),
    .p_reset_vector(32'h200)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t        sb[$];
  logic [31:0] mq[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          first_deq = -1;
  int          last_deq = -1;
  bit          track_rate = 0;
  bit          mem_hold = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // cycle counter
  always @(posedge clk) cyc_n++;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d words undelivered, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_full(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #4;
      if (bus.count == 3'd4) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL fill: got count %0d, want 4 within %0d cycles", bus.count, budget);
    end
  endtask

  // Memory model: accepts every request, answers in order one cycle later
  // unless held; forgets pending requests while reset is asserted.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      mq.delete();
      bus.imem_resp_val  = 1'b0;
      bus.imem_resp_data = 32'h0;
    end else if (!mem_hold && mq.size() > 0) begin
      bus.imem_resp_val  = 1'b1;
      bus.imem_resp_data = mem_word(mq[0]);
    end else begin
      bus.imem_resp_val  = 1'b0;
      bus.imem_resp_data = 32'h0;
    end
    #1;
    if (bus.imem_resp_val && bus.imem_resp_rdy) void'(mq.pop_front());
    if (bus.imem_req_val && bus.imem_req_rdy) mq.push_back(bus.imem_req_addr);
  end

  // Decode consumes only while the scoreboard still expects instructions.
  always @(negedge clk) begin
    #1;
    bus.inst_rdy = (sb.size() > 0);
  end

  // Monitor: every decode handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (reset && bus.inst_val && bus.inst_rdy) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL inst_seq: got pc=%h data=%h, want no instruction", bus.inst_pc, bus.inst_data);
      end else begin
        e = sb.pop_front();
        if (bus.inst_pc !== e.pc || bus.inst_data !== e.data) begin
          n_fail++;
          $display("FAIL inst_seq: got pc=%h data=%h, want pc=%h data=%h",
                   bus.inst_pc, bus.inst_data, e.pc, e.data);
        end
      end
      if (track_rate) begin
        if (first_deq < 0) first_deq = cyc_n;
        last_deq = cyc_n;
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.redirect_val = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.imem_req_rdy = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #4;
    chk("rst_req_val",  32'(bus.imem_req_val),  32'd0);
    chk("rst_resp_rdy", 32'(bus.imem_resp_rdy), 32'd0);
    chk("rst_inst_val", 32'(bus.inst_val),      32'd0);
    chk("rst_count",    32'(bus.count),         32'd0);
    chk("rst_inst_data", bus.inst_data,         32'h0);
    chk("rst_inst_pc",   bus.inst_pc,           32'h0);

    // first cycle out of reset
    @(negedge clk);
    reset = 1'b1;
    #4;
    chk("boot_req_val",  32'(bus.imem_req_val),  32'd1);
    chk("boot_req_addr", bus.imem_req_addr,      32'h200);
    chk("boot_resp_rdy", 32'(bus.imem_resp_rdy), 32'd1);

    // streaming, one instruction per cycle
    track_rate = 1;
    for (int i = 0; i < 8; i++) exp_push(32'h200 + 32'(4 * i));
    wait_drain(60);
    track_rate = 0;
    chk("stream_rate", 32'(last_deq - first_deq), 32'd7);

    // backpressure: decode stalls, queue saturates, requests stop
    repeat (20) @(negedge clk);
    #4;
    chk("bp_count",   32'(bus.count),        32'd4);
    chk("bp_req_val", 32'(bus.imem_req_val), 32'd0);
    for (int i = 0; i < 8; i++) exp_push(32'h220 + 32'(4 * i));
    wait_drain(60);

    // redirect with 2 queued and 2 in flight (depth-4 credit caps the sum at 4)
    wait_full(30);
    mem_hold = 1;
    exp_push(32'h240);
    exp_push(32'h244);
    wait_drain(20);
    repeat (3) @(negedge clk);
    #4;
    chk("pre_redir_count",   32'(bus.count),        32'd2);
    chk("pre_redir_req_val", 32'(bus.imem_req_val), 32'd0);
    @(negedge clk);
    bus.redirect_val = 1'b1;
    bus.redirect_pc  = 32'h1000;
    #4;
    chk("redir_req_val", 32'(bus.imem_req_val), 32'd0);
    @(negedge clk);
    bus.redirect_val = 1'b0;
    mem_hold = 0;
    #4;
    chk("redir_count",    32'(bus.count),        32'd0);
    chk("redir_inst_val", 32'(bus.inst_val),     32'd0);
    chk("redir_req_val2", 32'(bus.imem_req_val), 32'd1);
    chk("redir_req_addr", bus.imem_req_addr,     32'h1000);
    for (int i = 0; i < 4; i++) exp_push(32'h1000 + 32'(4 * i));
    wait_drain(40);

    // redirect coinciding with a response fire and a decode fire
    wait_full(30);
    mem_hold = 1;
    exp_push(32'h1010);
    exp_push(32'h1014);
    wait_drain(20);
    repeat (3) @(negedge clk);
    exp_push(32'h1018);
    bus.redirect_val = 1'b1;
    bus.redirect_pc  = 32'h2000;
    mem_hold = 0;
    #4;
    chk("coinc_inst_val",  32'(bus.inst_val), 32'd1);
    chk("coinc_resp_fire", 32'(bus.imem_resp_val & bus.imem_resp_rdy), 32'd1);
    @(negedge clk);
    bus.redirect_val = 1'b0;
    #4;
    chk("coinc_count",    32'(bus.count),        32'd0);
    chk("coinc_req_val",  32'(bus.imem_req_val), 32'd1);
    chk("coinc_req_addr", bus.imem_req_addr,     32'h2000);
    exp_push(32'h2000);
    exp_push(32'h2004);
    exp_push(32'h2008);
    wait_drain(40);

    // address wrap-around
    wait_full(30);
    @(negedge clk);
    bus.redirect_val = 1'b1;
    bus.redirect_pc  = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect_val = 1'b0;
    #4;
    chk("wrap_count",    32'(bus.count),    32'd0);
    chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    exp_push(32'hFFFF_FFF8);
    exp_push(32'hFFFF_FFFC);
    exp_push(32'h0000_0000);
    exp_push(32'h0000_0004);
    wait_drain(40);

    // reset mid-stream with a full queue
    wait_full(30);
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("mrst_inst_val", 32'(bus.inst_val),      32'd0);
    chk("mrst_req_val",  32'(bus.imem_req_val),  32'd0);
    chk("mrst_count",    32'(bus.count),         32'd0);
    chk("mrst_resp_rdy", 32'(bus.imem_resp_rdy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #4;
    chk("mrst_boot_val",  32'(bus.imem_req_val), 32'd1);
    chk("mrst_boot_addr", bus.imem_req_addr,     32'h200);
    chk("mrst_inst_val2", 32'(bus.inst_val),     32'd0);
    exp_push(32'h200);
    exp_push(32'h204);
    exp_push(32'h208);
    wait_drain(40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
